cu_seq: RTL and testbench

CU_SEQ -- requirements
Module: cu_seq

---
 rtl/cu_seq.sv | 185 ++++++++++++++++++
 tb/tb_cu_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_seq.sv
// rtl/cu_seq.sv - fetch/decode/execute control sequencer for an 8-bit accumulator core.
// Opcode in ir[7:5]; ir[4:0] is the operand address or the long sub-op.
module cu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] imem_ad,
    input  logic [7:0] imem_out,
    input  logic       acc_neg,
    input  logic       dp_ack,
    output logic [4:0] mem_ad,
    output logic       op_lda,
    output logic       op_add,
    output logic       op_sta,
    output logic       op_cla,
    output logic       op_csl,
    output logic       op_shr,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    localparam logic [2:0] CU_LONG = 3'b000;
    localparam logic [2:0] CU_LDA  = 3'b001;
    localparam logic [2:0] CU_ADD  = 3'b010;
    localparam logic [2:0] CU_STA  = 3'b011;
    localparam logic [2:0] CU_JMP  = 3'b100;
    localparam logic [2:0] CU_BAN  = 3'b101;

    localparam logic [4:0] CU_STOP = 5'h00;
    localparam logic [4:0] CU_CLA  = 5'h01;
    localparam logic [4:0] CU_CSL  = 5'h02;
    localparam logic [4:0] CU_SHR  = 5'h03;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic       r_err;

    state_t     w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [7:0] w_ir_nxt;
    logic       w_err_nxt;
    logic       w_lda;
    logic       w_add;
    logic       w_sta;
    logic       w_cla;
    logic       w_csl;
    logic       w_shr;
    logic [2:0] w_opc;
    logic [4:0] w_arg;

    assign w_opc = r_ir[7:5];
    assign w_arg = r_ir[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= 8'h00;
            r_ir    <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Strobes decode from state and ir only, so imem_out never reaches an output.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_err_nxt   = r_err;
        w_lda       = 1'b0;
        w_add       = 1'b0;
        w_sta       = 1'b0;
        w_cla       = 1'b0;
        w_csl       = 1'b0;
        w_shr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_ir_nxt    = imem_out;
                w_pc_nxt    = r_pc + 8'd1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (w_opc)
                    CU_LDA: begin
                        w_lda       = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                    CU_ADD: begin
                        w_add       = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                    CU_STA: begin
                        w_sta       = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                    CU_JMP: begin
                        w_pc_nxt    = {3'b000, w_arg};
                        w_state_nxt = S_FETCH;
                    end
                    CU_BAN: begin
                        if (acc_neg) begin
                            w_pc_nxt = {3'b000, w_arg};
                        end
                        w_state_nxt = S_FETCH;
                    end
                    CU_LONG: begin
                        case (w_arg)
                            CU_CLA: begin
                                w_cla       = 1'b1;
                                w_state_nxt = S_FETCH;
                            end
                            CU_CSL: begin
                                w_csl       = 1'b1;
                                w_state_nxt = S_FETCH;
                            end
                            CU_SHR: begin
                                w_shr       = 1'b1;
                                w_state_nxt = S_FETCH;
                            end
                            CU_STOP: begin
                                w_state_nxt = S_HALT;
                            end
                            default: begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = S_HALT;
                            end
                        endcase
                    end
                    default: begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                endcase
            end
            // Only an ack seen here counts; one already high during EXEC is ignored.
            S_WAIT: begin
                if (dp_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_ad = r_pc;
    assign mem_ad  = w_arg;
    assign op_lda  = w_lda;
    assign op_add  = w_add;
    assign op_sta  = w_sta;
    assign op_cla  = w_cla;
    assign op_csl  = w_csl;
    assign op_shr  = w_shr;
    assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted  = (r_state == S_HALT);
    assign err     = r_err;

endmodule

// File: tb/tb_cu_seq.sv
// tb/tb_cu_seq.sv - scoreboard bench for cu_seq.
// Strobes are checked by kind, operand address and cycle relative to start.
module tb_cu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] imem_ad;
    logic [7:0] imem_out;
    logic       acc_neg;
    logic       dp_ack;
    logic [4:0] mem_ad;
    logic       op_lda, op_add, op_sta, op_cla, op_csl, op_shr;
    logic       busy, halted, err;

    logic [7:0] imem [0:255];
    assign imem_out = imem[imem_ad];

    cu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_ad(imem_ad), .imem_out(imem_out),
        .acc_neg(acc_neg), .dp_ack(dp_ack), .mem_ad(mem_ad),
        .op_lda(op_lda), .op_add(op_add), .op_sta(op_sta),
        .op_cla(op_cla), .op_csl(op_csl), .op_shr(op_shr),
        .busy(busy), .halted(halted), .err(err)
    );

    // Strobe kinds: 0 lda, 1 add, 2 sta, 3 cla, 4 csl, 5 shr
    typedef struct { int kind; int mad; int cyc; } exp_t;
    typedef struct { int cyc; int ad; } iad_t;
    exp_t sb_q[$];
    iad_t ia_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int ack_delay = 1;
    bit ack_early = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic push_exp(input int k, input int m, input int c);
        exp_t e;
        e.kind = k; e.mad = m; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic push_ia(input int c, input int a);
        iad_t e;
        e.cyc = c; e.ad = a;
        ia_q.push_back(e);
    endtask

    always @(negedge clk) begin
        int n;
        int k;
        exp_t e;
        n = int'(op_lda) + int'(op_add) + int'(op_sta) + int'(op_cla) + int'(op_csl) + int'(op_shr);
        if (n != 0) begin
            chk("strobe_onehot", n, 1);
            k = op_lda ? 0 : op_add ? 1 : op_sta ? 2 : op_cla ? 3 : op_csl ? 4 : 5;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe kind=%0d mem_ad=%0d cycle=%0d expected=none", k, mem_ad, cyc - t0 + 1);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (k != e.kind || int'(mem_ad) != e.mad || (cyc - t0 + 1) != e.cyc) begin
                    failures++;
                    $display("FAIL strobe actual kind=%0d mem_ad=%0d cycle=%0d expected kind=%0d mem_ad=%0d cycle=%0d",
                             k, mem_ad, cyc - t0 + 1, e.kind, e.mad, e.cyc);
                end
            end
        end
    end

    always begin
        @(negedge clk);
        if ((op_lda || op_add || op_sta) && ack_delay > 0) begin
            if (ack_early) dp_ack = 1'b1;
            for (int k = 1; k <= ack_delay; k++) begin
                @(negedge clk);
                dp_ack = (k == ack_delay);
            end
            @(negedge clk);
            dp_ack = 1'b0;
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        dp_ack = 1'b0;
        sb_q.delete();
        ia_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_imem();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int exp_halt, input int exp_err, input int budget);
        bit seen;
        int rel;
        iad_t ie;
        seen = 0;
        pulse_start();
        for (int n = 0; n < budget && !seen; n++) begin
            rel = cyc - t0 + 1;
            while (ia_q.size() > 0 && ia_q[0].cyc == rel) begin
                ie = ia_q.pop_front();
                chk("imem_ad", imem_ad, ie.ad);
            end
            if (halted) begin
                seen = 1;
                chk("halt_cycle", rel, exp_halt);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) chk("halt_timeout", 0, 1);
        chk("err", err, exp_err);
        chk("sb_empty", sb_q.size(), 0);
        chk("ia_empty", ia_q.size(), 0);
    endtask

    function automatic int strobes();
        return {26'd0, op_lda, op_add, op_sta, op_cla, op_csl, op_shr};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; acc_neg = 1'b0; dp_ack = 1'b0;
        clear_imem();
        repeat (3) @(negedge clk);
        chk("rst_imem_ad", imem_ad, 0);
        chk("rst_mem_ad", mem_ad, 0);
        chk("rst_strobes", strobes(), 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);

        // lda 1, add 2, sta 1, stop
        do_reset();
        ack_delay = 1;
        imem[0] = 8'h21; imem[1] = 8'h42; imem[2] = 8'h61; imem[3] = 8'h00;
        push_exp(0, 1, 3); push_exp(1, 2, 7); push_exp(2, 1, 11);
        push_ia(1, 0); push_ia(5, 1); push_ia(13, 3);
        run(16, 0, 40);

        // jmp 6 ; at 6 jmp 8 ; cla csl shr stop
        do_reset();
        imem[0] = 8'h86; imem[6] = 8'h88; imem[7] = 8'h29;
        imem[8] = 8'h01; imem[9] = 8'h02; imem[10] = 8'h03; imem[11] = 8'h00;
        push_exp(3, 1, 9); push_exp(4, 2, 12); push_exp(5, 3, 15);
        push_ia(4, 6); push_ia(7, 8); push_ia(16, 11);
        run(19, 0, 40);

        // ban 1 taken
        do_reset();
        acc_neg = 1'b1;
        imem[0] = 8'h84; imem[4] = 8'hA1; imem[5] = 8'h27; imem[1] = 8'h23;
        push_exp(0, 3, 9);
        push_ia(4, 4); push_ia(7, 1); push_ia(11, 2);
        run(14, 0, 40);

        // ban 1 not taken
        do_reset();
        acc_neg = 1'b0;
        imem[0] = 8'h84; imem[4] = 8'hA1; imem[5] = 8'h27; imem[1] = 8'h23;
        push_exp(0, 7, 9);
        push_ia(7, 5); push_ia(11, 6);
        run(14, 0, 40);

        // undefined long sub-op, then start pulses must not leave HALT
        do_reset();
        imem[0] = 8'h1F;
        run(4, 1, 20);
        repeat (3) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("halt_sticky", halted, 1);
        chk("halt_busy", busy, 0);
        chk("err_sticky", err, 1);

        // undefined opcode 3'b110
        do_reset();
        chk("err_cleared", err, 0);
        imem[0] = 8'hC5;
        run(4, 1, 20);

        // ack high during EXEC must be ignored; real ack arrives after 3 WAIT cycles
        do_reset();
        ack_delay = 3; ack_early = 1'b1;
        imem[0] = 8'h63; imem[1] = 8'h00;
        push_exp(2, 3, 3);
        push_ia(7, 1);
        run(10, 0, 30);
        ack_early = 1'b0; ack_delay = 1;

        // async reset during WAIT with a pending ack
        do_reset();
        ack_delay = 0;
        imem[0] = 8'h24;
        push_exp(0, 4, 3);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_mem_ad", mem_ad, 4);
        #2;
        dp_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_imem_ad", imem_ad, 0);
        chk("arst_mem_ad", mem_ad, 0);
        chk("arst_strobes", strobes(), 0);
        chk("arst_busy", busy, 0);
        chk("arst_halted", halted, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        dp_ack = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_imem_ad", imem_ad, 0);
        chk("post_rst_sb", sb_q.size(), 0);
        ack_delay = 1;

        // pc wrap: ban 5 taken, cla run to 8'hFF, wrap to 0, ban not taken, stop at 1
        do_reset();
        acc_neg = 1'b1;
        imem[0] = 8'hA5;
        for (int a = 5; a < 256; a++) begin
            imem[a] = 8'h01;
            push_exp(3, 1, 6 + 3 * (a - 5));
        end
        push_ia(754, 255); push_ia(757, 0); push_ia(760, 1);
        fork
            begin
                repeat (6) @(negedge clk);
                acc_neg = 1'b0;
            end
        join_none
        run(763, 0, 900);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
